// File: rtl/rf_pkg.sv
// Shared constants and write-port priority helper for the reg_file_sb register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned ZERO_REG  = 0;
  localparam int unsigned WR_MAX    = 4;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } wr_sel_t;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wr_sel_t wr_pick(input logic [WR_MAX-1:0] hit);
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < WR_MAX; j++) begin
      if (hit[j]) begin
        sel.found = 1'b1;
        sel.idx   = 2'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between issue/writeback (master) and the register file (slave).
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_addr,
    output rdata, rbusy, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags: issue sets, writeback clears, set wins on collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NWR   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  output logic [NREGS-1:0]  busy_vec_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             set, clr;

  always_comb begin
    busy_d = '0;
    set    = 1'b0;
    clr    = 1'b0;
    for (int r = ZERO_REG + 1; r < NREGS; r++) begin
      clr = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        clr = clr | (we_i[j] && (waddr_i[j*AW +: AW] == AW'(r)));
      end
      set       = iss_valid_i && (iss_addr_i == AW'(r));
      busy_d[r] = set || (!clr && busy_q[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with x0 hardwired to zero and a busy scoreboard.
// Define REG_FILE_BYPASS_EN for write-first reads (same-cycle write-to-read bypass).
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave rf
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_vec;

  function automatic logic [WR_MAX-1:0] wr_hits(input logic [NWR-1:0]    we,
                                                 input logic [NWR*AW-1:0] waddr,
                                                 input logic [AW-1:0]     a);
    logic [WR_MAX-1:0] h;
    h = '0;
    for (int j = 0; j < NWR; j++) begin
      h[j] = we[j] && (waddr[j*AW +: AW] == a);
    end
    return h;
  endfunction

  always_comb begin
    wr_sel_t sel;
    sel = '0;
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
    end
    mem_d[ZERO_REG] = '0;
    for (int r = ZERO_REG + 1; r < NREGS; r++) begin
      sel = wr_pick(wr_hits(rf.we, rf.waddr, AW'(r)));
      if (sel.found) begin
        mem_d[r] = rf.wdata[sel.idx*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NWR   (NWR)
  ) u_sb (
    .clk_i       (clk),
    .rst_i       (rst),
    .iss_valid_i (rf.iss_valid),
    .iss_addr_i  (rf.iss_addr),
    .we_i        (rf.we),
    .waddr_i     (rf.waddr),
    .busy_vec_o  (busy_vec)
  );

  assign rf.busy_vec = busy_vec;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rf.raddr[i*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
    wr_sel_t bsel;
    logic    byp;
    logic    iss_same;
    assign bsel     = wr_pick(wr_hits(rf.we, rf.waddr, ra));
    assign byp      = bsel.found && (ra != AW'(ZERO_REG));
    assign iss_same = rf.iss_valid && (rf.iss_addr == ra);
    // A retiring write hides the busy bit unless a new producer claims the register this cycle.
    assign rf.rdata[i*XLEN +: XLEN] = byp ? rf.wdata[bsel.idx*XLEN +: XLEN] : mem_q[ra];
    assign rf.rbusy[i]              = (byp && !iss_same) ? 1'b0 : busy_vec[ra];
`else
    assign rf.rdata[i*XLEN +: XLEN] = mem_q[ra];
    assign rf.rbusy[i]              = busy_vec[ra];
`endif
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard. It is the successor to the single-write, dual-read core register file. It adds configurable width, depth, read and write port counts, synchronous clear, same-cycle write-to-read bypass, and pending-write tracking for the issue stage. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived; do not override)
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
raddr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rdata  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rbusy  out  NRD  busy bit of each read address
we  in  NWR  write enables
waddr  in  NWR*AW  write addresses
wdata  in  NWR*XLEN  write data
iss_valid  in  1  issue strobe: mark iss_addr busy
iss_addr  in  AW  destination register being issued
busy_vec  out  NREGS  full scoreboard, bit r = register r pending

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk.
- With rst high at a rising edge:
  - all NREGS registers clear to 0 and all busy bits clear to 0;
  - we and iss_valid are ignored in that cycle.
- From the cycle after reset: rdata = 0, rbusy = 0, busy_vec = 0.
- Register 0 is hardwired zero:
  - writes to address 0 are dropped;
  - issue to address 0 never sets busy;
  - reads of address 0 return 0 with rbusy = 0.
- Reads are combinational, zero latency from raddr.
- Writes commit at the rising edge when we[j] = 1. Read ports see the written value no later than the following cycle.
- Multiple write ports targeting the same address in one cycle: the highest-index port wins, for both data and bypass.
- Scoreboard, per register r (r != 0), evaluated at each edge:
  - set = iss_valid && iss_addr == r
  - clr = any we[j] with waddr[j] == r
  - next busy = set ? 1 : (clr ? 0 : busy). Set has priority, because a same-cycle new producer supersedes the retiring one.
- rbusy[i] = busy_vec[raddr[i]] as registered state. It is not bypassed by same-cycle clr.
- No back-pressure. Issuing to an already-busy register is legal and keeps it busy; the stall decision belongs to the issue stage.
- Reset asserted mid-operation discards all pending writes and busy state. Nothing issued before reset is tracked afterwards.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined:
  - if any we[j] matches raddr[i] (raddr[i] != 0), rdata[i] returns the winning wdata in the same cycle (write-first);
  - rbusy[i] is forced to 0 for that port in that cycle, unless iss_valid also targets the same address in that cycle.
- Undefined: rdata shows the pre-write array contents and rbusy the registered state (read-first). Callers must wait one cycle after writeback.

Decomposition:
- Shared package rf_pkg holds:
  - default constants XLEN_DEF = 32, NREGS_DEF = 32;
  - the zero-register address constant;
  - the function computing write-port priority (highest matching index, plus a found flag).
- One sub-module, rf_scoreboard: NREGS busy flops with the set/clr priority logic. It takes iss_valid/iss_addr and per-port we/waddr, and outputs busy_vec.
- The array, read muxing and bypass stay in reg_file_sb.

Test Plan:
1. Reset, then read all addresses on every port -> rdata = 0, rbusy = 0, busy_vec = 0.
2. Write x5 = 0xDEADBEEF; next cycle read x5 on port 0 and x0 on port 1 -> 0xDEADBEEF, 0. Then write x0 = 0x1234 -> x0 still reads 0.
3. NWR = 2, same edge we = 2'b11, waddr = {7, 7}, wdata = {0xBBBB, 0xAAAA} -> x7 = 0xBBBB (port 1 wins).
4. Issue x3; next cycle rbusy for x3 = 1 and busy_vec[3] = 1. Writeback x3 = 0x55 -> busy clears the edge after. Issue x3 and write x3 in the same cycle -> busy_vec[3] stays 1.
5. With REG_FILE_BYPASS_EN, write x9 = 0x77 while reading x9 in the same cycle -> rdata = 0x77, rbusy = 0. Without the macro -> old value, and 0x77 the next cycle.
6. Load several registers and mark them busy, assert rst for one cycle while we = 1 -> all regs and busy bits read 0 afterwards, and the concurrent write is not committed.
